uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of flip-flops in the rx input synchronizer (min 2).
REQ-002 Port: clk  input  1  system clock; all logic SHALL be on posedge clk.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: rx  input  1  serial line, idle high, asynchronous to clk.
REQ-005 Port: dll  input  8  divisor low byte.
REQ-006 Port: dlh  input  4  divisor high nibble; D = {dlh,dll} clocks per bit.
REQ-007 Port: rx_rd  input  1  one-cycle read strobe; consumes held byte.
REQ-008 Port: rx_data  output  8  received byte, LSB first on line.
REQ-009 Port: rx_valid  output  1  level; held byte unread.
REQ-010 Port: frame_err  output  1  stop bit of held byte sampled 0.
REQ-011 Port: overrun  output  1  sticky; a frame completed while rx_valid=1.
REQ-012 Port: parity_err  output  1  held byte failed parity (PARITY_EN only; tied 0 otherwise).

Function
REQ-013 rx SHALL pass through SYNC_STAGES flops (reset value 1); all decisions use synchronized value rs.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY (PARITY_EN only), STOP, BREAK.
REQ-015 IDLE: rs=0 -> START; 12-bit divisor D latched at that edge; D changes mid-frame ignored.
REQ-016 D<2 SHALL keep FSM in IDLE (receiver disabled).
REQ-017 START: after floor(D/2) clocks, sample rs; 0 -> DATA, 1 -> IDLE (false start, no flags).
REQ-018 DATA: sample every D clocks from start mid-sample; 8 bits shifted LSB first; bit counter 0..7.
REQ-019 After bit 7: -> PARITY if PARITY_EN, else -> STOP; next sample D clocks later.
REQ-020 STOP sample: rs=1 -> IDLE same edge; rs=0 -> BREAK, frame_err for this byte = 1.
REQ-021 BREAK: wait until rs=1, then -> IDLE (no start detected during break).
REQ-022 Completion edge = STOP sample edge: rx_data, frame_err, parity_err load; rx_valid=1 from next cycle.
REQ-023 rx_rd with rx_valid=1 SHALL clear rx_valid next cycle; rx_data holds value.
REQ-024 rx_rd with rx_valid=0 SHALL be ignored.
REQ-025 Completion while rx_valid=1 and no rx_rd: data overwritten, overrun=1.
REQ-026 Completion and rx_rd same cycle: new byte loads, rx_valid stays 1, overrun unchanged.
REQ-027 overrun SHALL clear only on rst, or on rx_rd when rx_valid=1.
REQ-028 Sample counter SHALL be 12-bit, reloaded each sample; no wrap beyond D-1.

Reset
REQ-029 rst=1 at any clk edge, including mid-frame: FSM=IDLE, counters=0, synchronizer=all 1, rx_data=0x00, rx_valid=0, frame_err=0, parity_err=0, overrun=0.
REQ-030 Partial frame in progress at reset SHALL be discarded; first start detection needs rs=1 then 0 after reset release.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: PARITY state present; even parity over 8 data bits plus parity bit; mismatch -> parity_err=1 for that byte; frame = 11 bits.
REQ-032 Macro UART_RX_PARITY_EN undefined: no PARITY state, parity_err constant 0, frame = 10 bits.

Verification
REQ-033 dlh=0, dll=16, frame 0xA5 (8N1): rx_valid rises exactly 1 cycle after the stop-bit sample, which occurs 16*9+8 clocks after rs falls; rx_data=0xA5, frame_err=0.
REQ-034 D=16, rx low 5 clocks then high: no rx_valid, FSM back in IDLE, flags 0.
REQ-035 D=16, 0x3C then 0xC3 with no rx_rd: rx_data=0xC3, overrun=1; rx_rd -> rx_valid=0, overrun=0.
REQ-036 D=16, 0x55 with stop bit 0, line held low 40 clocks then high: frame_err=1; no second frame until line high; next 0x01 received clean.
REQ-037 D=16, rst pulsed at bit 4 of 0xFF, then 0x12 sent: only 0x12 reported, no overrun.
REQ-038 UART_RX_PARITY_EN, D=16, 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, divisor, read strobe and receive status for uart_rx.
// master = the side that drives the line and reads bytes; slave = the receiver.
// fsm_state is a debug view of the receiver state:
//   0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP, 5 BREAK.
`timescale 1ns/1ps

interface uart_rx_if;
    logic       rx;
    logic [7:0] dll;
    logic [3:0] dlh;
    logic       rx_rd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic [2:0] fsm_state;

    modport master (
        output rx, dll, dlh, rx_rd,
        input  rx_data, rx_valid, frame_err, overrun, parity_err, fsm_state
    );

    modport slave (
        input  rx, dll, dlh, rx_rd,
        output rx_data, rx_valid, frame_err, overrun, parity_err, fsm_state
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling-free UART receiver, one sample per bit at mid-bit.
// Divisor D = {dlh,dll} clocks per bit, latched at start detection; D < 2
// disables the receiver. Optional even parity bit when UART_RX_PARITY_EN is
// defined (frame 11 bits); otherwise 8N1 (frame 10 bits) and parity_err = 0.
//
// Read handshake: rx_valid is a level meaning "held byte unread". rx_rd is a
// one-cycle strobe; it consumes the byte only when rx_valid=1 (clearing
// rx_valid and overrun next cycle) and is ignored otherwise. rx_data keeps
// its value after a read. A new byte arriving while rx_valid=1 without a
// same-cycle rx_rd overwrites rx_data and sets the sticky overrun flag.
`timescale 1ns/1ps

module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs;

    logic [11:0] div_in;
    logic [11:0] div_q, div_d;
    logic [11:0] cnt_q, cnt_d;
    logic [11:0] half;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        at_half;
    logic        at_bit;
    logic        complete;

`ifdef UART_RX_PARITY_EN
    logic        par_q, par_d;
`endif

    logic [7:0]  data_q;
    logic        valid_q;
    logic        fe_q;
    logic        pe_q;
    logic        ovr_q;

    assign rs      = sync_q[SYNC_STAGES-1];
    assign div_in  = {bus.dlh, bus.dll};
    assign half    = div_q >> 1;
    // Start bit is sampled at its middle; every later bit one full period on.
    assign at_half = (cnt_q == half - 12'd1);
    assign at_bit  = (cnt_q == div_q - 12'd1);

    // Input synchronizer; resets to idle-high so reset never looks like a start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx};
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= 12'd0;
            cnt_q   <= 12'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic: sample counter reloads at each sample point.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        complete = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rs && div_in >= 12'd2) begin
                    state_d = START;
                    div_d   = div_in;
                    cnt_d   = 12'd0;
                end
            end
            START: begin
                if (at_half) begin
                    cnt_d = 12'd0;
                    if (!rs) begin
                        state_d = DATA;
                        bit_d   = 3'd0;
                    end else begin
                        // Glitch shorter than half a bit: drop it silently.
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            DATA: begin
                if (at_bit) begin
                    cnt_d   = 12'd0;
                    shift_d = {rs, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_bit) begin
                    cnt_d   = 12'd0;
                    par_d   = rs;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
`endif
            STOP: begin
                if (at_bit) begin
                    cnt_d    = 12'd0;
                    complete = 1'b1;
                    // A low stop bit means the line may be in break; wait
                    // for it to go high before hunting for a new start.
                    state_d  = rs ? IDLE : BREAK;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            BREAK: begin
                if (rs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Holding register and status flags, updated at the stop-bit sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (complete) begin
            data_q  <= shift_q;
            fe_q    <= ~rs;
`ifdef UART_RX_PARITY_EN
            pe_q    <= ^{shift_q, par_q};
`else
            pe_q    <= 1'b0;
`endif
            valid_q <= 1'b1;
            // A same-cycle read makes room for the new byte: no overrun,
            // and an existing overrun is left as it is.
            if (valid_q && !bus.rx_rd) begin
                ovr_q <= 1'b1;
            end
        end else if (bus.rx_rd && valid_q) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end
    end

    assign bus.rx_data    = data_q;
    assign bus.rx_valid   = valid_q;
    assign bus.frame_err  = fe_q;
    assign bus.parity_err = pe_q;
    assign bus.overrun    = ovr_q;
    assign bus.fsm_state  = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed vector table, hand-written corner sequences and a
// randomized section checked against a queue-based model of the receiver.
// Build with +define+UART_RX_PARITY_EN to exercise the parity variant.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 10;   // 8 data + parity + stop, after start
`else
    localparam int FRAME_BITS = 9;    // 8 data + stop, after start
`endif
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_BREAK = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_if bus();

    uart_rx #(.SYNC_STAGES(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: unread bytes since the last effective read.
    logic [7:0] exp_q[$];
    logic [7:0] m_data;
    logic       m_pe;
    logic       m_ovr;

    typedef struct {
        logic [7:0] data;
        logic       rd;
        logic [7:0] exp_data;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                             input logic fe, input logic pe, input logic ovr);
        check({tag, ".rx_valid"},   32'(bus.rx_valid),   32'(v));
        check({tag, ".rx_data"},    32'(bus.rx_data),    32'(d));
        check({tag, ".frame_err"},  32'(bus.frame_err),  32'(fe));
        check({tag, ".parity_err"}, 32'(bus.parity_err), 32'(pe));
        check({tag, ".overrun"},    32'(bus.overrun),    32'(ovr));
    endtask

    function automatic logic good_par(input logic [7:0] b);
        return ^b;
    endfunction

    function automatic logic exp_pe(input logic [7:0] b, input logic par);
`ifdef UART_RX_PARITY_EN
        return par ^ (^b);
`else
        return 1'b0 & par & b[0];
`endif
    endfunction

    function automatic void model_frame(input logic [7:0] b, input logic pe);
        if (exp_q.size() > 0) m_ovr = 1'b1;
        exp_q.push_back(b);
        m_data = b;
        m_pe   = pe;
    endfunction

    function automatic void model_read();
        if (exp_q.size() > 0) begin
            exp_q.delete();
            m_ovr = 1'b0;
        end
    endfunction

    task automatic set_div(input int d);
        bus.dll = d[7:0];
        bus.dlh = d[11:8];
    endtask

    // Drives one frame at d clocks per bit, starting now (#1 after an edge).
    // A low stop bit leaves the line low on return; otherwise the line is
    // left idle for a few clocks so the receiver finishes the frame.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                              input int d, input logic scramble);
        bus.rx = 1'b0;
        repeat (d) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            if (scramble && i == 1) begin
                bus.dll = 8'($urandom);
                bus.dlh = 4'($urandom);
            end
            repeat (d) @(posedge clk);
            #1;
        end
`ifdef UART_RX_PARITY_EN
        bus.rx = par;
        repeat (d) @(posedge clk);
        #1;
`else
        if (par === 1'bx) bus.rx = 1'b1;
`endif
        bus.rx = stop;
        repeat (d) @(posedge clk);
        #1;
        if (scramble) set_div(d);
        if (stop) begin
            repeat (6) @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_pulse();
        bus.rx_rd = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_rd = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int off;
        bus.rx    = 1'b1;
        bus.rx_rd = 1'b0;
        set_div(16);
        m_data = 8'h00;
        m_pe   = 1'b0;
        m_ovr  = 1'b0;

        vecs[0] = '{data: 8'hA5, rd: 1'b1, exp_data: 8'hA5, exp_ovr: 1'b0};
        vecs[1] = '{data: 8'h3C, rd: 1'b0, exp_data: 8'h3C, exp_ovr: 1'b0};
        vecs[2] = '{data: 8'hC3, rd: 1'b1, exp_data: 8'hC3, exp_ovr: 1'b1};
        vecs[3] = '{data: 8'h00, rd: 1'b1, exp_data: 8'h00, exp_ovr: 1'b0};
        vecs[4] = '{data: 8'hFF, rd: 1'b0, exp_data: 8'hFF, exp_ovr: 1'b0};
        vecs[5] = '{data: 8'h81, rd: 1'b1, exp_data: 8'h81, exp_ovr: 1'b1};

        // Reset state
        repeat (4) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset.fsm_state", 32'(bus.fsm_state), 32'(ST_IDLE));
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // 0xA5 at D=16: stop sample lands SYNC+1+8+16*9 clocks after drive
        off = SYNC + 1 + 16 / 2 + FRAME_BITS * 16;
        fork
            send_frame(8'hA5, good_par(8'hA5), 1'b1, 16, 1'b0);
            begin
                repeat (off - 1) @(posedge clk);
                #1;
                check("a5_timing.before_stop", 32'(bus.rx_valid), 32'd0);
                @(posedge clk);
                #1;
                check("a5_timing.after_stop", 32'(bus.rx_valid), 32'd1);
            end
        join
        check_out("a5", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        rd_pulse();

        // Vector table
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, good_par(vecs[i].data), 1'b1, 16, 1'b0);
            check_out($sformatf("vec%0d", i), 1'b1, vecs[i].exp_data, 1'b0, 1'b0, vecs[i].exp_ovr);
            if (vecs[i].rd) begin
                rd_pulse();
                check_out($sformatf("vec%0d_rd", i), 1'b0, vecs[i].exp_data, 1'b0, 1'b0, 1'b0);
            end
        end

        // Read with nothing held is ignored
        rd_pulse();
        check_out("idle_rd", 1'b0, 8'h81, 1'b0, 1'b0, 1'b0);

        // False start: 5 low clocks is shorter than half a bit
        bus.rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.rx = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_out("false_start", 1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
        check("false_start.fsm_state", 32'(bus.fsm_state), 32'(ST_IDLE));

        // Divisor below 2 disables the receiver
        set_div(1);
        send_frame(8'h5A, good_par(8'h5A), 1'b1, 16, 1'b0);
        check_out("div_lt2", 1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
        check("div_lt2.fsm_state", 32'(bus.fsm_state), 32'(ST_IDLE));
        set_div(16);
        repeat (4) @(posedge clk);
        #1;

        // Framing error followed by a held-low break
        send_frame(8'h55, good_par(8'h55), 1'b0, 16, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check_out("break", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        check("break.fsm_state", 32'(bus.fsm_state), 32'(ST_BREAK));
        rd_pulse();
        repeat (200) @(posedge clk);
        #1;
        check("break_hold.rx_valid", 32'(bus.rx_valid), 32'd0);
        bus.rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send_frame(8'h01, good_par(8'h01), 1'b1, 16, 1'b0);
        check_out("after_break", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        rd_pulse();

        // Completion and read in the same cycle keep rx_valid and overrun
        send_frame(8'h11, good_par(8'h11), 1'b1, 16, 1'b0);
        send_frame(8'h22, good_par(8'h22), 1'b1, 16, 1'b0);
        check_out("ovr_setup", 1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
        fork
            send_frame(8'h33, good_par(8'h33), 1'b1, 16, 1'b0);
            begin
                repeat (off - 1) @(posedge clk);
                #1;
                bus.rx_rd = 1'b1;
                @(posedge clk);
                #1;
                bus.rx_rd = 1'b0;
            end
        join
        check_out("rd_at_done", 1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        rd_pulse();
        check_out("rd_at_done_clr", 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of 0xFF at bit 4, with a byte left unread
        send_frame(8'h77, good_par(8'h77), 1'b1, 16, 1'b0);
        fork
            send_frame(8'hFF, good_par(8'hFF), 1'b1, 16, 1'b0);
            begin
                repeat (5 * 16 + 8) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join
        check_out("mid_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("mid_reset.fsm_state", 32'(bus.fsm_state), 32'(ST_IDLE));
        send_frame(8'h12, good_par(8'h12), 1'b1, 16, 1'b0);
        check_out("post_reset", 1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        rd_pulse();
        m_data = 8'h12;

`ifdef UART_RX_PARITY_EN
        // Parity: 0x07 has three ones, so the even-parity bit must be 1
        send_frame(8'h07, 1'b0, 1'b1, 16, 1'b0);
        check_out("par_bad", 1'b1, 8'h07, 1'b0, 1'b1, 1'b0);
        rd_pulse();
        send_frame(8'h07, 1'b1, 1'b1, 16, 1'b0);
        check_out("par_good", 1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
        rd_pulse();
        m_data = 8'h07;
`endif

        // Randomized frames, divisors, parity and reads against the model
        for (int i = 0; i < 14; i++) begin
            int         d;
            logic [7:0] b;
            logic       par;
            d   = int'($urandom_range(2, 40));
            b   = 8'($urandom);
            par = good_par(b) ^ ($urandom_range(0, 3) == 0);
            set_div(d);
            repeat (2) @(posedge clk);
            #1;
            send_frame(b, par, 1'b1, d, 1'b1);
            model_frame(b, exp_pe(b, par));
            check_out($sformatf("rand%0d", i), exp_q.size() > 0, m_data, 1'b0, m_pe, m_ovr);
            if ($urandom_range(0, 1) == 1) begin
                rd_pulse();
                model_read();
                check_out($sformatf("rand%0d_rd", i), exp_q.size() > 0, m_data, 1'b0, m_pe, m_ovr);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
